mac_seq: RTL and testbench
==========================

# mac_seq

Job-level sequencer that sits in front of the `mac` datapath and owns its instruction, operand and stall inputs. It accepts a dot-product command, streams N operand pairs from a valid/ready source into the MAC as one multiply followed by multiply-accumulates, and optionally appends a saturate. It then drains the MAC pipeline and holds the captured result on a valid/ready output. One job is in flight at a time.

## Interface

- `LEN_W`, 8: width of `cmd_len`.
- `MAC_LAT`, 3: unstalled cycles from an instruction being presented to its result on `mac_result`.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_mode` in 1: 0 = 32-bit mode, 1 = dual 8-bit lanes.
- `cmd_len` in LEN_W: number of operand pairs, 0..2^LEN_W-1.
- `cmd_sat` in 1: append a saturate instruction.
- `op_valid` in 1, `op_ready` out 1: operand handshake.
- `op_a`, `op_b` in 16: signed operands. In dual mode, [15:8] is the upper lane and [7:0] the lower lane.
- `res_valid` in/out: `res_valid` out 1, `res_ready` in 1.
- `res_data` out 32, `res_prot` out 8: result and guard bits.
- `mac_instruction` out 3, `mac_multiplier` out 16, `mac_multiplicand` out 16, `mac_stall` out 1: drive the MAC.
- `mac_result` in 32, `mac_protect` in 8: MAC outputs.

## Operation

- States: IDLE, ISSUE, SAT, DRAIN, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch mode, len and sat, and clear the pair counter.
  - len≠0 → ISSUE.
  - len=0 → DRAIN, with a clear (000/100) issued in the accept cycle.
- **ISSUE**
  - `op_ready`=1.
  - `mac_multiplier`/`mac_multiplicand` = `op_a`/`op_b` combinationally.
  - Instruction: first pair → 001 (mode 0) / 101 (mode 1); later pairs → 010 / 110.
  - `mac_stall` = !`op_valid`, so a missing operand freezes the whole MAC pipeline.
  - After pair len: if sat → SAT, else → DRAIN.
- **SAT**
  - Issue 011 / 111 with `mac_stall`=0 for one cycle, then → DRAIN.
- **DRAIN**
  - Lasts MAC_LAT cycles with `mac_stall`=0.
  - Filler instruction is clear of the job mode (000/100); operands are 0.
  - At the end of the last DRAIN cycle, capture `mac_result` into `res_data`.
  - Capture `res_prot` = `mac_protect` when sat=0, 8'h00 when sat=1.
  - Then → DONE.
- **DONE**
  - `res_valid`=1, with data held stable until `res_ready`.
  - The transfer cycle → IDLE.
- Outside ISSUE stall cycles, `mac_stall`=0.
- In IDLE and DONE: `mac_instruction`=000 and operands 0.
- Dual mode lane mapping: the low lane maps to `res_data[15:0]`/`res_prot[3:0]`; the high lane maps to [31:16]/[7:4].

## Timing

- Reset values:
  - `cmd_ready`=1 (state IDLE).
  - `op_ready`=0, `res_valid`=0, `res_data`=0, `res_prot`=0.
  - `mac_instruction`=000, `mac_multiplier`/`mac_multiplicand`=0, `mac_stall`=0.
- Latency with an uninterrupted operand stream:
  - Accept in cycle 0; pairs issue in cycles 1..N; SAT in cycle N+1 if enabled.
  - DRAIN occupies the next MAC_LAT cycles.
  - `res_valid` rises in cycle N+1+MAC_LAT (sat=0) or N+2+MAC_LAT (sat=1).
- Each `op_valid`=0 cycle in ISSUE adds one cycle of latency.
- The drain counter counts only unstalled cycles; stalls never occur in DRAIN.
- A `cmd_valid` arriving outside IDLE is not accepted; the sequencer does not overlap jobs.
- In DONE with `res_ready`=0, hold indefinitely. The next command can be accepted at the earliest one cycle after the result transfer.
- Asserting `reset_n`=0 in any state forces all reset values immediately.
  - The in-flight job is discarded.
  - The MAC is reset by the same `reset_n` at system level.
- The counter and `cmd_len` comparison are LEN_W wide; len=2^LEN_W-1 must not wrap.

## Configuration

- `MAC_SEQ_PERF_EN` defined:
  - Adds outputs `perf_jobs` (32) and `perf_stall` (32), both reset to 0 and saturating at all-ones.
  - `perf_jobs` increments on every result transfer.
  - `perf_stall` increments on every cycle with `mac_stall`=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure

- Shared package `mac_pkg` holds:
  - The 3-bit instruction encodings (CLR32, MUL32, MAC32, SAT32, CLR8, MUL8, MAC8, SAT8).
  - The state enum for the sequencer.
  - Default `MAC_LAT`.
- No sub-module: the FSM, pair counter, drain counter and result register fit in a single `mac_seq`.
- The bench instantiates `mac_seq` driving a real `mac`.

## Test plan

- **32-bit dot product:** mode 0, len 4, sat 0, pairs (3,4),(−2,5),(100,100),(−1,−1), continuous → `res_data`=32'd10003, `res_prot`=0, `res_valid` in cycle 8.
- **Dual lanes:** mode 1, len 2, `op_a`/`op_b` = 16'h02_03/16'h04_05 then 16'hFF_02/16'h03_02 → upper lane 8−3=5, lower 15+4=19 → `res_data`=32'h0005_0013.
- **Saturation:** mode 0, sat 1, len 3, each pair (16'h8000,16'h8000) → `res_data`=32'h7FFF_FFFF, `res_prot`=0; with sat 0 the same job gives `res_prot`=8'h00, `res_data`=32'hC000_0000.
- **Operand gaps and backpressure:** `op_valid` low 2 cycles mid-job → `mac_stall` high exactly 2 cycles, result unchanged; `res_ready` low 5 cycles → `res_data` stable, `cmd_ready`=0 throughout.
- **Zero length:** len 0 → `res_data`=0, `res_prot`=0, `res_valid` in cycle 1+MAC_LAT.
- **Reset mid-job:** `reset_n` pulsed low during ISSUE → all outputs at reset values that cycle; the following len 1 job (7,6) returns 42.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: MAC instruction encodings, sequencer state encoding and default MAC pipeline latency.
package mac_pkg;
    localparam logic [2:0] CLR32 = 3'b000;
    localparam logic [2:0] MUL32 = 3'b001;
    localparam logic [2:0] MAC32 = 3'b010;
    localparam logic [2:0] SAT32 = 3'b011;
    localparam logic [2:0] CLR8  = 3'b100;
    localparam logic [2:0] MUL8  = 3'b101;
    localparam logic [2:0] MAC8  = 3'b110;
    localparam logic [2:0] SAT8  = 3'b111;
    localparam int DEF_MAC_LAT = 3;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SAT, S_DRAIN, S_DONE} seq_state_t;
endpackage

// File: rtl/mac.sv
// mac: 3-stage signed MAC; 32-bit accumulate with 8 guard bits, or two 8-bit lanes with 4 guard bits each.
// A stall freezes every pipeline register, including capture of the presented instruction.
module mac import mac_pkg::*; (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  instruction,
    input  logic [15:0] multiplier,
    input  logic [15:0] multiplicand,
    input  logic        stall,
    output logic [31:0] result,
    output logic [7:0]  protect
);
    logic [2:0]         r_ins1, r_ins2;
    logic [15:0]        r_a, r_b;
    logic signed [31:0] r_p32;
    logic signed [15:0] r_ph, r_pl;
    logic [39:0]        r_acc, w_acc, w_sum;
    logic [19:0]        w_hi, w_lo;
    logic               r_mode;

    function automatic logic [39:0] sat40(input logic [39:0] x);
        return (&x[39:31] || ~|x[39:31]) ? x : (x[39] ? 40'hFF_8000_0000 : 40'h00_7FFF_FFFF);
    endfunction

    function automatic logic [19:0] sat20(input logic [19:0] x);
        return (&x[19:15] || ~|x[19:15]) ? x : (x[19] ? 20'hF_8000 : 20'h0_7FFF);
    endfunction

    always_comb begin
        w_hi  = r_acc[39:20] + 20'($signed(r_ph));
        w_lo  = r_acc[19:0] + 20'($signed(r_pl));
        w_sum = r_acc + 40'($signed(r_p32));
        case (r_ins2)
            MUL32:   w_acc = 40'($signed(r_p32));
            MUL8:    w_acc = {20'($signed(r_ph)), 20'($signed(r_pl))};
            MAC32:   w_acc = w_sum;
            MAC8:    w_acc = {w_hi, w_lo};
            SAT32:   w_acc = sat40(r_acc);
            SAT8:    w_acc = {sat20(r_acc[39:20]), sat20(r_acc[19:0])};
            default: w_acc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ins1 <= CLR32;
            r_ins2 <= CLR32;
            r_a    <= '0;
            r_b    <= '0;
            r_p32  <= '0;
            r_ph   <= '0;
            r_pl   <= '0;
            r_acc  <= '0;
            r_mode <= 1'b0;
        end else if (!stall) begin
            r_ins1 <= instruction;
            r_a    <= multiplier;
            r_b    <= multiplicand;
            r_ins2 <= r_ins1;
            r_p32  <= 32'($signed(r_a)) * 32'($signed(r_b));
            r_ph   <= 16'($signed(r_a[15:8])) * 16'($signed(r_b[15:8]));
            r_pl   <= 16'($signed(r_a[7:0])) * 16'($signed(r_b[7:0]));
            r_acc  <= w_acc;
            r_mode <= r_ins2[2];
        end
    end

    assign result  = r_mode ? {r_acc[35:20], r_acc[15:0]} : r_acc[31:0];
    assign protect = r_mode ? {r_acc[39:36], r_acc[19:16]} : r_acc[39:32];
endmodule

// File: rtl/mac_seq.sv
// mac_seq: one-job-at-a-time sequencer streaming operand pairs into the mac and holding its result.
// Defining MAC_SEQ_PERF_EN adds saturating perf_jobs / perf_stall counters.
module mac_seq import mac_pkg::*; #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_sat,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [7:0]       res_prot,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    output logic             mac_stall,
`ifdef MAC_SEQ_PERF_EN
    output logic [31:0]      perf_jobs,
    output logic [31:0]      perf_stall,
`endif
    input  logic [31:0]      mac_result,
    input  logic [7:0]       mac_protect
);
    localparam int DW = $clog2(MAC_LAT + 1);

    seq_state_t       r_state, w_next;
    logic             r_mode, r_sat;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [DW-1:0]    r_drain;
    logic [31:0]      r_data;
    logic [7:0]       r_prot;
    logic             w_accept, w_last_pair, w_drain_end;

    assign w_accept    = r_state == S_IDLE && cmd_valid;
    assign w_last_pair = r_cnt == r_len - LEN_W'(1);
    assign w_drain_end = r_state == S_DRAIN && r_drain == DW'(MAC_LAT - 1);
    assign cmd_ready   = r_state == S_IDLE;
    assign op_ready    = r_state == S_ISSUE;
    assign res_valid   = r_state == S_DONE;
    assign res_data    = r_data;
    assign res_prot    = r_prot;

    always_comb begin
        w_next           = r_state;
        mac_instruction  = CLR32;
        mac_multiplier   = '0;
        mac_multiplicand = '0;
        mac_stall        = 1'b0;
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_next          = cmd_len == '0 ? S_DRAIN : S_ISSUE;
                mac_instruction = (cmd_len == '0 && cmd_mode) ? CLR8 : CLR32;
            end
            S_ISSUE: begin
                mac_instruction  = r_cnt == '0 ? (r_mode ? MUL8 : MUL32) : (r_mode ? MAC8 : MAC32);
                mac_multiplier   = op_a;
                mac_multiplicand = op_b;
                mac_stall        = !op_valid;
                if (op_valid && w_last_pair) w_next = r_sat ? S_SAT : S_DRAIN;
            end
            S_SAT: begin
                mac_instruction = r_mode ? SAT8 : SAT32;
                w_next          = S_DRAIN;
            end
            S_DRAIN: begin
                mac_instruction = r_mode ? CLR8 : CLR32;
                if (w_drain_end) w_next = S_DONE;
            end
            S_DONE: if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_sat   <= 1'b0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_data  <= '0;
            r_prot  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mode  <= cmd_mode;
                r_len   <= cmd_len;
                r_sat   <= cmd_sat;
                r_cnt   <= '0;
                r_drain <= '0;
            end
            if (op_ready && op_valid) r_cnt <= r_cnt + LEN_W'(1);
            if (r_state == S_DRAIN) r_drain <= r_drain + DW'(1);
            if (w_drain_end) begin
                r_data <= mac_result;
                r_prot <= r_sat ? 8'h00 : mac_protect;
            end
        end
    end

`ifdef MAC_SEQ_PERF_EN
    logic [31:0] r_jobs, r_stalls;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jobs   <= '0;
            r_stalls <= '0;
        end else begin
            if (res_valid && res_ready && !(&r_jobs)) r_jobs <= r_jobs + 32'd1;
            if (mac_stall && !(&r_stalls)) r_stalls <= r_stalls + 32'd1;
        end
    end

    assign perf_jobs  = r_jobs;
    assign perf_stall = r_stalls;
`endif
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed jobs through mac_seq driving a real mac; results checked against a queue of expected values.
module tb_mac_seq;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_mode = 1'b0, cmd_sat = 1'b0;
    logic [7:0]  cmd_len = '0;
    logic        op_valid = 1'b0, res_ready = 1'b1;
    logic [15:0] op_a = 16'h1234, op_b = 16'h5678;
    logic        cmd_ready, op_ready, res_valid, mac_stall;
    logic [31:0] res_data, mac_result;
    logic [7:0]  res_prot, mac_protect;
    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier, mac_multiplicand;

    int total = 0, bad = 0, cyc = 0, stall_cnt = 0;
    logic [39:0] exp_q[$];
    logic [15:0] pa[256], pb[256];

    mac_seq dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_sat(cmd_sat),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_prot(res_prot),
        .mac_instruction(mac_instruction), .mac_multiplier(mac_multiplier),
        .mac_multiplicand(mac_multiplicand), .mac_stall(mac_stall),
        .mac_result(mac_result), .mac_protect(mac_protect)
    );

    mac u_mac (
        .clk(clk), .reset_n(reset_n), .instruction(mac_instruction),
        .multiplier(mac_multiplier), .multiplicand(mac_multiplicand), .stall(mac_stall),
        .result(mac_result), .protect(mac_protect)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mac_stall) stall_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_prot", res_prot, 0);
        chk("rst_instr", mac_instruction, 0);
        chk("rst_mult", mac_multiplier, 0);
        chk("rst_mcand", mac_multiplicand, 0);
        chk("rst_stall", mac_stall, 0);
    endtask

    task automatic fill(input int n, input logic [15:0] a, input logic [15:0] b);
        for (int k = 0; k < n; k++) begin
            pa[k] = a;
            pb[k] = b;
        end
    endtask

    task automatic run_job(input logic m, input int n, input logic s, input int gap_at, input int gap_n,
                           input int hold, input logic [31:0] ed, input logic [7:0] ep);
        int c0, s0, gaps, i, guard;
        logic [39:0] e;
        exp_q.push_back({ep, ed});
        step();
        cmd_valid = 1'b1; cmd_mode = m; cmd_len = 8'(n); cmd_sat = s; res_ready = (hold == 0);
        #1;
        chk("cmd_ready", cmd_ready, 1);
        if (n == 0) chk("zero_len_clear", mac_instruction, {m, 2'b00});
        c0 = cyc; s0 = stall_cnt; gaps = 0; i = 0;
        while (i < n) begin
            step();
            cmd_valid = 1'b0;
            op_valid = !(i == gap_at && gaps < gap_n);
            op_a = pa[i]; op_b = pb[i];
            #1;
            chk("op_ready", op_ready, 1);
            if (op_valid) begin
                chk("issue_instr", mac_instruction, {m, i == 0 ? 2'b01 : 2'b10});
                i++;
            end else gaps++;
        end
        step();
        cmd_valid = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
        #1;
        guard = 0;
        while (!res_valid && guard < 400) begin
            step();
            #1;
            guard++;
        end
        chk("latency", cyc - c0, n + 4 + int'(s) + gap_n);
        chk("stall_cycles", stall_cnt - s0, gap_n);
        for (int k = 0; k < hold; k++) begin
            chk("hold_data", res_data, ed);
            chk("hold_valid", res_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            step();
            #1;
        end
        res_ready = 1'b1;
        #1;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, e[31:0]);
        chk("res_prot", res_prot, e[39:32]);
        step();
        #1;
        chk("post_valid", res_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values();
        reset_n = 1'b1;
        op_a = '0; op_b = '0;

        pa[0] = 16'd3;   pb[0] = 16'd4;
        pa[1] = -16'sd2; pb[1] = 16'd5;
        pa[2] = 16'd100; pb[2] = 16'd100;
        pa[3] = -16'sd1; pb[3] = -16'sd1;
        run_job(1'b0, 4, 1'b0, -1, 0, 0, 32'd10003, 8'h00);
        run_job(1'b0, 4, 1'b0, 2, 2, 5, 32'd10003, 8'h00);

        pa[0] = 16'h0203; pb[0] = 16'h0405;
        pa[1] = 16'hFF02; pb[1] = 16'h0302;
        run_job(1'b1, 2, 1'b0, -1, 0, 0, 32'h0005_0013, 8'h00);
        pa[0] = 16'h0180; pb[0] = 16'h017F;
        run_job(1'b1, 1, 1'b0, -1, 0, 0, 32'h0001_C080, 8'h0F);

        fill(4, 16'h8000, 16'h8000);
        run_job(1'b0, 3, 1'b1, -1, 0, 0, 32'h7FFF_FFFF, 8'h00);
        run_job(1'b0, 3, 1'b0, -1, 0, 0, 32'hC000_0000, 8'h00);
        run_job(1'b0, 4, 1'b0, -1, 0, 0, 32'h0000_0000, 8'h01);
        fill(3, 16'h8000, 16'h7FFF);
        run_job(1'b0, 3, 1'b1, -1, 0, 0, 32'h8000_0000, 8'h00);
        run_job(1'b0, 3, 1'b0, -1, 0, 0, 32'h4001_8000, 8'hFF);

        run_job(1'b0, 0, 1'b0, -1, 0, 0, 32'h0, 8'h00);
        run_job(1'b1, 0, 1'b0, -1, 0, 2, 32'h0, 8'h00);

        fill(255, 16'd1, 16'd1);
        run_job(1'b0, 255, 1'b0, -1, 0, 0, 32'd255, 8'h00);

        step();
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_len = 8'd4; cmd_sat = 1'b0;
        step();
        cmd_valid = 1'b0; op_valid = 1'b1; op_a = 16'd5; op_b = 16'd5;
        step();
        #1;
        chk("pre_reset_issue", op_ready, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values();
        step();
        reset_n = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;

        pa[0] = 16'd7; pb[0] = 16'd6;
        run_job(1'b0, 1, 1'b0, -1, 0, 0, 32'd42, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
